ct_vfalu_issue_ctrl: RTL and testbench
======================================

CT_VFALU_ISSUE_CTRL -- requirements
Module: ct_vfalu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: forever_cpuclk (clock) and cpurst_b (reset, async, active-low).
REQ-002 The ports SHALL be, in this order:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  async active-low reset
- idu_vfpu_rf_pipex_vld  in  1  issue request valid
- idu_vfpu_rf_pipex_sel  in  3  unit select, one-hot: [0] misc (L=1), [1] fadd (L=3), [2] fcnv (L=2)
- idu_vfpu_rf_pipex_iid  in  7  instruction id
- rtu_yy_xx_flush  in  1  pipeline flush
- vfpu_idu_pipex_ready  out  1  issue accept condition
- dp_vfalu_ex1_pipex_sel  out  3  registered EX1 unit select to the datapath
- vfalu_wb_vld  out  1  writeback valid
- vfalu_wb_sel  out  3  one-hot unit producing the writeback
- vfalu_wb_iid  out  7  iid of the writeback
- vfalu_busy  out  1  any op in flight

Function
REQ-003 The block SHALL accept an issue in cycle t iff vld=1, ready=1 and sel is one-hot.
REQ-004 A request with vld=1 and sel zero or multi-hot SHALL be dropped, with no state change.
REQ-005 Writeback tracking SHALL use a 4-entry shift register wb_pipe[3:0], each entry holding {vld, sel[2:0], iid[6:0]}. Every cycle entry i SHALL load entry i+1, entry 3 SHALL load empty, and wb outputs SHALL be driven directly from entry 0.
REQ-006 On accept, the shifted-in value SHALL be overwritten with the request at index j = 1 (misc), 2 (fcnv) or 3 (fadd).
REQ-007 ready SHALL equal !flush && (sel[0] ? !wb_pipe[2].vld : sel[2] ? !wb_pipe[3].vld : 1).
- fadd is never blocked.
- ready is combinational from sel, flush and state.
REQ-008 Latency SHALL be accept at t -> dp_vfalu_ex1_pipex_sel = sel in cycle t+1 (for exactly one cycle) -> wb_vld in cycle t+1+L. That is: misc at t+2, fcnv at t+3, fadd at t+4.
REQ-009 If no accept occurs in cycle t, dp_vfalu_ex1_pipex_sel SHALL be 3'b000 in cycle t+1.
REQ-010 At most one wb_vld SHALL occur per cycle; no two in-flight ops SHALL ever target the same writeback cycle.
REQ-011 Back-to-back accepts every cycle SHALL be supported subject to REQ-007.
REQ-012 The block SHALL allow a younger, shorter-latency op to write back before an older fadd op; ordering is by latency, not by issue order.
REQ-013 When wb_vld=0, vfalu_wb_sel and vfalu_wb_iid SHALL be 0.
REQ-014 Flush asserted in cycle t SHALL:
- force ready=0 in cycle t, so no accept occurs in t;
- clear dp_vfalu_ex1_pipex_sel and all wb_pipe entries at the t edge;
- give wb_vld=0 from t+1.
A wb_vld already present in cycle t SHALL still be output in t.
REQ-015 vfalu_busy SHALL equal |dp_vfalu_ex1_pipex_sel | any wb_pipe[3:1].vld.

Reset
REQ-016 Asynchronous assertion of cpurst_b SHALL clear all of: wb_pipe, dp_vfalu_ex1_pipex_sel=0, vfalu_wb_vld=0, vfalu_wb_sel=0, vfalu_wb_iid=0, vfalu_busy=0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight ops; no wb_vld for them SHALL appear after reset release.
REQ-018 In the first cycle after reset release, ready SHALL be 1 for any one-hot sel with flush=0.

Verification
REQ-019 Single fadd: accept sel=3'b010, iid=5 at t0 -> ex1_sel=010 at t1, then wb_vld=1 with wb_sel=010, wb_iid=5 at t4, and busy low at t4.
REQ-020 Collision: fadd iid=1 accepted at t0, then misc iid=2 requested at t2 -> ready=0 at t2; the misc request held to t3 is accepted, and the writebacks are iid1@t4, iid2@t5.
REQ-021 Reorder: fadd iid=1 at t0, misc iid=2 at t1 -> wb iid2@t3, iid1@t4.
REQ-022 Flush: fadd at t0, fcnv at t1, flush at t2 -> ready=0 at t2, no wb_vld from t3 onward, busy=0 at t3.
REQ-023 Illegal select: vld=1, sel=3'b011 -> no ex1_sel, no wb_vld, state unchanged.
REQ-024 Reset mid-flight: cpurst_b low for one cycle at t2 after fadd at t0 -> all outputs 0 immediately, and no wb_vld at t4.

Source files
------------

// File: rtl/ct_vfalu_issue_ctrl.sv
// ct_vfalu_issue_ctrl: VFALU issue acceptance and fixed-latency writeback tracking
//   forever_cpuclk / cpurst_b        : clock, async active-low reset
//   idu_vfpu_rf_pipex_vld/sel/iid    : issue request (sel one-hot: [0] misc, [1] fadd, [2] fcnv)
//   rtu_yy_xx_flush                  : discard everything in flight
//   vfpu_idu_pipex_ready             : request can be accepted this cycle
//   dp_vfalu_ex1_pipex_sel           : unit select of the op in EX1
//   vfalu_wb_vld/sel/iid             : writeback slot leaving the tracker
//   vfalu_busy                       : any op still in flight
module ct_vfalu_issue_ctrl (
    input  logic       forever_cpuclk,
    input  logic       cpurst_b,
    input  logic       idu_vfpu_rf_pipex_vld,
    input  logic [2:0] idu_vfpu_rf_pipex_sel,
    input  logic [6:0] idu_vfpu_rf_pipex_iid,
    input  logic       rtu_yy_xx_flush,
    output logic       vfpu_idu_pipex_ready,
    output logic [2:0] dp_vfalu_ex1_pipex_sel,
    output logic       vfalu_wb_vld,
    output logic [2:0] vfalu_wb_sel,
    output logic [6:0] vfalu_wb_iid,
    output logic       vfalu_busy
);
    // entry layout {vld, sel[2:0], iid[6:0]}; entry 0 is the writeback slot
    logic [3:0][10:0] wb_pipe;
    logic [3:0][10:0] wb_pipe_nxt;
    logic             sel_onehot;
    logic             issue_acc;
    logic [1:0]       issue_idx;
    assign sel_onehot = (idu_vfpu_rf_pipex_sel == 3'b001) || (idu_vfpu_rf_pipex_sel == 3'b010)
                     || (idu_vfpu_rf_pipex_sel == 3'b100);
    // a shorter op would land in the slot that an older op shifts into next cycle
    assign vfpu_idu_pipex_ready = !rtu_yy_xx_flush &&
                                  (idu_vfpu_rf_pipex_sel[0] ? !wb_pipe[2][10] :
                                   idu_vfpu_rf_pipex_sel[2] ? !wb_pipe[3][10] : 1'b1);
    assign issue_acc = idu_vfpu_rf_pipex_vld && vfpu_idu_pipex_ready && sel_onehot;
    assign issue_idx = idu_vfpu_rf_pipex_sel[0] ? 2'd1 : idu_vfpu_rf_pipex_sel[2] ? 2'd2 : 2'd3;
    always_comb begin
        wb_pipe_nxt = {11'b0, wb_pipe[3:1]};
        if (issue_acc)
            wb_pipe_nxt[issue_idx] = {1'b1, idu_vfpu_rf_pipex_sel, idu_vfpu_rf_pipex_iid};
    end
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wb_pipe                <= '0;
            dp_vfalu_ex1_pipex_sel <= 3'b000;
        end else begin
            wb_pipe                <= rtu_yy_xx_flush ? '0 : wb_pipe_nxt;
            dp_vfalu_ex1_pipex_sel <= issue_acc ? idu_vfpu_rf_pipex_sel : 3'b000;
        end
    end
    assign vfalu_wb_vld = wb_pipe[0][10];
    assign vfalu_wb_sel = wb_pipe[0][10] ? wb_pipe[0][9:7] : 3'b000;
    assign vfalu_wb_iid = wb_pipe[0][10] ? wb_pipe[0][6:0] : 7'd0;
    assign vfalu_busy   = (|dp_vfalu_ex1_pipex_sel) || wb_pipe[3][10] || wb_pipe[2][10] || wb_pipe[1][10];
endmodule

// File: tb/tb_ct_vfalu_issue_ctrl.sv
// tb_ct_vfalu_issue_ctrl: directed stimulus with a due-cycle ordered writeback scoreboard
module tb_ct_vfalu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       vld = 1'b0;
    logic [2:0] sel = 3'b000;
    logic [6:0] iid = 7'd0;
    logic       flush = 1'b0;
    logic       ready;
    logic [2:0] ex1_sel;
    logic       wb_vld;
    logic [2:0] wb_sel;
    logic [6:0] wb_iid;
    logic       busy;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [2:0] exp_ex1 = 3'b000;
    typedef struct {
        int         due;
        logic [2:0] sel;
        logic [6:0] iid;
    } exp_t;
    exp_t q[$];

    ct_vfalu_issue_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst_b(rst_b),
        .idu_vfpu_rf_pipex_vld(vld),
        .idu_vfpu_rf_pipex_sel(sel),
        .idu_vfpu_rf_pipex_iid(iid),
        .rtu_yy_xx_flush(flush),
        .vfpu_idu_pipex_ready(ready),
        .dp_vfalu_ex1_pipex_sel(ex1_sel),
        .vfalu_wb_vld(wb_vld),
        .vfalu_wb_sel(wb_sel),
        .vfalu_wb_iid(wb_iid),
        .vfalu_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [2:0] s);
        return s[0] ? 1 : s[2] ? 2 : 3;
    endfunction

    function automatic logic onehot(input logic [2:0] s);
        return s == 3'b001 || s == 3'b010 || s == 3'b100;
    endfunction

    task automatic push(input int due, input logic [2:0] s, input logic [6:0] id);
        exp_t e;
        int   k;
        e.due = due;
        e.sel = s;
        e.iid = id;
        k = q.size();
        for (int i = 0; i < q.size(); i++)
            if (q[i].due > due) begin
                k = i;
                break;
            end
        q.insert(k, e);
    endtask

    // scoreboard monitor: pops on every writeback, flags missing/unexpected ones
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_vld) begin
                if (q.size() == 0) chk("wb_unexpected_iid", {25'd0, wb_iid}, 32'hffff_ffff);
                else begin
                    chk("wb_iid", {25'd0, wb_iid}, {25'd0, q[0].iid});
                    chk("wb_sel", {29'd0, wb_sel}, {29'd0, q[0].sel});
                    chk("wb_cycle", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end else begin
                chk("wb_idle_zero", {21'd0, wb_sel, wb_iid}, 32'd0);
                if (q.size() != 0 && q[0].due <= cyc) begin
                    chk("wb_missing_iid", 32'hffff_ffff, {25'd0, q[0].iid});
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic [2:0] s, input logic [6:0] id,
                        input logic f, input logic exp_rdy, input int exp_busy);
        @(posedge clk);
        #1;
        vld = v;
        sel = s;
        iid = id;
        flush = f;
        @(negedge clk);
        chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
        chk("ex1_sel", {29'd0, ex1_sel}, {29'd0, exp_ex1});
        if (exp_busy >= 0) chk("busy", {31'd0, busy}, exp_busy[0] ? 32'd1 : 32'd0);
        exp_ex1 = 3'b000;
        if (v && exp_rdy && onehot(s)) begin
            push(cyc + 1 + lat(s), s, id);
            exp_ex1 = s;
        end
        if (f)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].due > cyc) q.delete(i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b010, 7'd0, 1'b0, 1'b1, -1);
    endtask

    task automatic reset_pulse();
        #2;
        rst_b = 1'b0;
        vld = 1'b0;
        #1;
        chk("rst_outputs", {19'd0, wb_vld, wb_sel, wb_iid, ex1_sel, busy}, 32'd0);
        q.delete();
        exp_ex1 = 3'b000;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {19'd0, wb_vld, wb_sel, wb_iid, ex1_sel, busy}, 32'd0);
        rst_b = 1'b1;
        mon_en = 1'b1;
        step(0, 3'b001, 0, 0, 1, 0);
        // single fadd, wb four cycles after issue
        step(1, 3'b010, 5, 0, 1, 0);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 0);
        idle(1);
        // misc blocked by fadd collision, then accepted
        step(1, 3'b010, 1, 0, 1, 0);
        step(0, 3'b010, 0, 0, 1, 1);
        step(1, 3'b001, 2, 0, 0, 1);
        step(1, 3'b001, 2, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 0);
        idle(1);
        // younger misc overtakes older fadd
        step(1, 3'b010, 1, 0, 1, 0);
        step(1, 3'b001, 2, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 0);
        idle(1);
        // fcnv blocked behind fadd, then accepted
        step(1, 3'b010, 11, 0, 1, 0);
        step(1, 3'b100, 12, 0, 0, 1);
        step(1, 3'b100, 12, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 0);
        idle(1);
        // flush kills in-flight ops
        step(1, 3'b010, 3, 0, 1, 0);
        step(1, 3'b100, 4, 0, 0, 1);
        step(1, 3'b100, 4, 1, 0, 1);
        step(0, 3'b100, 0, 0, 1, 0);
        idle(4);
        // flush in the cycle of a writeback keeps that writeback
        step(1, 3'b010, 7, 0, 1, 0);
        step(0, 3'b010, 0, 0, 1, 1);
        step(1, 3'b001, 8, 0, 0, 1);
        step(1, 3'b001, 8, 0, 1, 1);
        step(0, 3'b001, 0, 1, 0, 1);
        step(0, 3'b001, 0, 0, 1, 0);
        idle(3);
        // back-to-back misc issues
        step(1, 3'b001, 20, 0, 1, -1);
        step(1, 3'b001, 21, 0, 1, -1);
        step(1, 3'b001, 22, 0, 1, -1);
        step(1, 3'b001, 23, 0, 1, -1);
        idle(3);
        // illegal selects are dropped
        step(1, 3'b011, 9, 0, 1, 0);
        step(1, 3'b000, 9, 0, 1, 0);
        step(1, 3'b110, 9, 0, 1, 0);
        step(0, 3'b001, 0, 0, 1, 0);
        idle(3);
        // reset mid-flight discards the fadd
        step(1, 3'b010, 10, 0, 1, 0);
        step(0, 3'b010, 0, 0, 1, 1);
        step(0, 3'b010, 0, 0, 1, 1);
        reset_pulse();
        step(0, 3'b001, 0, 0, 1, 0);
        step(0, 3'b100, 0, 0, 1, 0);
        idle(4);
        mon_en = 1'b0;
        while (q.size() != 0) begin
            chk("wb_never_seen_iid", 32'hffff_ffff, {25'd0, q[0].iid});
            void'(q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
